// File: rtl/pc_fetch_controller_pkg.sv
// Shared types and constants for the single-issue PC fetch sequencer.
package pc_fetch_controller_pkg;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_EXEC,
    ST_HALT
  } fetch_state_t;

  localparam int          JUMP_W           = 26;
  localparam int unsigned RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/pc_fetch_controller_if.sv
// Fetch-side bundle: imem request/response, decode handoff, execute resolution, halt/status.
interface pc_fetch_controller_if #(
  parameter int INSTR_ADDR_SIZE = 32
) ();
  import pc_fetch_controller_pkg::*;

  logic                       imem_req_valid;
  logic                       imem_req_ready;
  logic [INSTR_ADDR_SIZE-1:0] imem_req_addr;
  logic                       imem_resp_valid;
  logic [31:0]                imem_resp_data;

  logic                       instr_valid;
  logic                       instr_ready;
  logic [31:0]                instr;
  logic [INSTR_ADDR_SIZE-1:0] instr_pc;

  logic                       resolve_valid;
  logic                       resolve_branch;
  logic                       resolve_zero;
  logic                       resolve_jump;
  logic [INSTR_ADDR_SIZE-1:0] resolve_imm;
  logic [JUMP_W-1:0]          resolve_target;

  logic                       halt_req;
  logic                       halted;
  logic [31:0]                retired_count;

  // Controller side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  resolve_valid, resolve_branch, resolve_zero, resolve_jump,
    input  resolve_imm, resolve_target, halt_req,
    output halted, retired_count
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output resolve_valid, resolve_branch, resolve_zero, resolve_jump,
    output resolve_imm, resolve_target, halt_req,
    input  halted, retired_count
  );

endinterface

// File: rtl/pc_fetch_controller_pc_next_calc.sv
// Combinational next-PC: jump > taken branch (pc-relative) > fall-through.
module pc_next_calc
  import pc_fetch_controller_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]      pc,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic [W-1:0]      imm,
  input  logic [JUMP_W-1:0] target,
  output logic [W-1:0]      next_pc
);

  logic [W-1:0] pc1;

  assign pc1 = pc + W'(1);

  // Jump keeps the region bits of the fall-through address, so W must exceed JUMP_W.
  always_comb begin
    next_pc = pc1;
    if (jump)
      next_pc = {pc1[W-1:JUMP_W], target};
    else if (branch && zero)
      next_pc = pc + imm;
  end

endmodule

// File: rtl/pc_fetch_controller.sv
// Fetch sequencer: one instruction in flight, REQ -> WAIT -> ISSUE -> EXEC, then next PC.
module pc_fetch_controller
  import pc_fetch_controller_pkg::*;
#(
  parameter int                         INSTR_ADDR_SIZE = 32,
  parameter logic [INSTR_ADDR_SIZE-1:0] RESET_PC        = INSTR_ADDR_SIZE'(RESET_PC_DEFAULT)
) (
  input logic                  clk,
  input logic                  reset,
  pc_fetch_controller_if.master bus
);

  fetch_state_t               state;
  logic [INSTR_ADDR_SIZE-1:0] pc;
  logic [INSTR_ADDR_SIZE-1:0] next_pc;
  logic [INSTR_ADDR_SIZE-1:0] instr_pc_q;
  logic [31:0]                instr_q;
  logic [31:0]                retired_q;

  pc_next_calc #(.W(INSTR_ADDR_SIZE)) u_next (
    .pc      (pc),
    .branch  (bus.resolve_branch),
    .zero    (bus.resolve_zero),
    .jump    (bus.resolve_jump),
    .imm     (bus.resolve_imm),
    .target  (bus.resolve_target),
    .next_pc (next_pc)
  );

  // Each state only listens to its own input; everything else is ignored by construction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      retired_q  <= '0;
    end else begin
      unique case (state)
        ST_REQ:   if (bus.imem_req_ready) state <= ST_WAIT;
        ST_WAIT:
          if (bus.imem_resp_valid) begin
            instr_q    <= bus.imem_resp_data;
            instr_pc_q <= pc;
            state      <= ST_ISSUE;
          end
        ST_ISSUE: if (bus.instr_ready) state <= ST_EXEC;
        ST_EXEC:
          if (bus.resolve_valid) begin
            pc        <= next_pc;
            retired_q <= retired_q + 32'd1;
            state     <= bus.halt_req ? ST_HALT : ST_REQ;
          end
        ST_HALT:  state <= ST_HALT;
        default:  state <= ST_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid = (state == ST_REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = (state == ST_ISSUE);
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.halted         = (state == ST_HALT);
  assign bus.retired_count  = retired_q;

endmodule
